// File: rtl/dmem_io_pkg.sv
// Shared definitions for the data-memory responder: region select, I/O register
// offsets and console status bit layout.
package dmem_io_pkg;

  localparam int IO_SEL_BIT = 31;

  typedef enum logic [2:0] {
    CONSOLE_DATA   = 3'd0,
    CONSOLE_STATUS = 3'd1,
    CYCLE_COUNT    = 3'd2,
    LED            = 3'd3
  } io_reg_e;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_OCC_LSB = 8;

  // Assemble the CONSOLE_STATUS read word from its fields.
  function automatic logic [31:0] pack_status(input logic [7:0] occ,
                                              input logic       ovf,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] s;
    s                         = '0;
    s[ST_EMPTY]               = empty;
    s[ST_FULL]                = full;
    s[ST_OVF]                 = ovf;
    s[ST_OCC_LSB +: 8]        = occ;
    return s;
  endfunction

endpackage

// File: rtl/dmem_io_responder_fifo.sv
// Show-ahead synchronous FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so the slot being vacated is reused.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Head is forced to zero while empty so the port reads 0 after reset.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers and occupancy, flushed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dmem_io_responder.sv
// Data-memory bus responder for the single-cycle CPU: word RAM below
// 0x8000_0000, memory-mapped console/counter/LED page above it. Loads are
// combinational; stores commit on the rising edge.
module dmem_io_responder
  import dmem_io_pkg::*;
#(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  leds
);

  localparam int RAW = $clog2(RAM_WORDS);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]    ram_q [RAM_WORDS];
  logic [31:0]    cnt_q, cnt_d;
  logic [7:0]     leds_q, leds_d;
  logic           ovf_q, ovf_d;

  logic           io_sel;
  logic [RAW-1:0] ram_idx;
  logic [2:0]     io_off;
  logic           wr_ram, wr_io;
  logic           wr_con, wr_stat, wr_cnt, wr_led;

  logic           fifo_empty, fifo_full, fifo_pop, dropped;
  logic [CW-1:0]  fifo_count;
  logic [7:0]     occ8;
  logic           unused_bits;

  // Address decode; upper RAM address bits alias, adr[1:0] are ignored.
  assign io_sel  = adr[IO_SEL_BIT];
  assign ram_idx = adr[RAW+1:2];
  assign io_off  = adr[4:2];
  assign wr_ram  = memwrite && !io_sel;
  assign wr_io   = memwrite && io_sel;
  assign wr_con  = wr_io && (io_off == CONSOLE_DATA);
  assign wr_stat = wr_io && (io_off == CONSOLE_STATUS);
  assign wr_cnt  = wr_io && (io_off == CYCLE_COUNT);
  assign wr_led  = wr_io && (io_off == LED);

  assign unused_bits = ^{adr, writedata, fifo_count};

  // Console handshake: a pop is a valid/ready transfer; a push into a full
  // FIFO survives only when the head leaves in the same cycle.
  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;
  assign dropped  = wr_con && fifo_full && !fifo_pop;
  assign occ8     = 8'(fifo_count);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_con),
    .din   (writedata[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  // Next-state for counter, LEDs and sticky overflow flag.
  always_comb begin
    cnt_d  = wr_cnt ? writedata : cnt_q + 32'd1;
    leds_d = wr_led ? writedata[7:0] : leds_q;
    ovf_d  = ovf_q;
    if (wr_stat && writedata[ST_OVF]) ovf_d = 1'b0;
    if (dropped)                      ovf_d = 1'b1;
  end

  // I/O page registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      leds_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      leds_q <= leds_d;
      ovf_q  <= ovf_d;
    end
  end

  // Word RAM; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= writedata;
  end

  assign leds = leds_q;

  // Load mux; reads see pre-edge state, so same-cycle stores are not visible.
  always_comb begin
    readdata = '0;
    if (!io_sel) begin
      readdata = ram_q[ram_idx];
    end else begin
      case (io_off)
        CONSOLE_STATUS: readdata = pack_status(occ8, ovf_q, fifo_full, fifo_empty);
        CYCLE_COUNT:    readdata = cnt_q;
        LED:            readdata = {24'b0, leds_q};
        default:        readdata = '0;
      endcase
    end
  end

endmodule

// File: doc/dmem_io_responder.md
Name: dmem_io_responder

Overview:
- Responder side of the single-cycle CPU data-memory bus: serves loads combinationally and commits stores on the clock edge.
- Decodes the address into two regions: a word RAM, and a small memory-mapped I/O page.
- The I/O page holds a console transmit FIFO with a valid/ready drain port, a free-running cycle counter and an LED register.
- Sits beside the datapath; its `readdata` feeds the CPU result mux.

Parameters:
- RAM_WORDS, 64, number of 32-bit RAM words; power of two, ≥ 4.
- FIFO_DEPTH, 8, console FIFO entries; power of two, 2..256.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- memwrite  in  1  store strobe for the current cycle.
- adr  in  32  byte address (CPU aluout).
- writedata  in  32  store data.
- readdata  out  32  load data, combinational from `adr`.
- tx_data  out  8  console byte at FIFO head.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  consumer accepts `tx_data` this cycle.
- leds  out  8  LED register.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-high, named `reset`.
- Reset values:
  - FIFO empty: tx_valid=0, occupancy 0, tx_data=0.
  - overflow=0, cycle counter=0, leds=0.
  - RAM contents are not reset.
- Region decode:
  - adr[31]=0 selects RAM. Word index is adr[log2(RAM_WORDS)+1:2]; upper address bits are ignored, so the RAM aliases and wraps modulo its size.
  - adr[31]=1 selects I/O. The register is chosen by adr[4:2]; other bits are ignored.
  - adr[1:0] is always ignored (word access only).
- Reads: purely combinational, zero latency, required by the single-cycle CPU. A read in the same cycle as a write to the same location returns the pre-edge value.
- Writes: take effect at the rising edge while memwrite=1. No write occurs when memwrite=0.
- I/O map (offset = adr[4:2]):
  - 0 CONSOLE_DATA
    - Write pushes writedata[7:0].
    - If the FIFO is full and no pop happens this cycle, the byte is dropped and overflow is set (sticky).
    - Read returns 0.
  - 1 CONSOLE_STATUS
    - Read returns {16'b0, occupancy[7:0], 5'b0, overflow, full, empty}.
    - A write with writedata[2]=1 clears overflow. Other bits are ignored.
  - 2 CYCLE_COUNT
    - Read returns the counter value.
    - Write loads writedata, so the next cycle shows writedata (not +1), and counting resumes after that.
    - Otherwise the counter increments every cycle and wraps 0xFFFFFFFF→0.
  - 3 LED: read returns {24'b0, leds}; a write loads writedata[7:0].
  - 4..7: read 0, writes ignored.
- Console FIFO:
  - Show-ahead: tx_data always holds the head entry, and tx_valid = !empty.
  - Pop occurs when tx_valid && tx_ready.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - Simultaneous push and pop: both happen and occupancy is unchanged. This applies even when full, in which case the push is accepted and overflow is not set.
  - Pop on empty: ignored. tx_ready is don't-care while tx_valid=0.
  - Pointers wrap modulo FIFO_DEPTH. full is occupancy==FIFO_DEPTH.
- Reset mid-operation: the FIFO is flushed (queued bytes are lost) and tx_valid drops at the next edge. RAM is untouched.

Decomposition:
- Shared package `dmem_io_pkg` holds:
  - IO region select bit (31).
  - Register offsets CONSOLE_DATA=0, CONSOLE_STATUS=1, CYCLE_COUNT=2, LED=3.
  - Status bit positions EMPTY=0, FULL=1, OVF=2, OCC_LSB=8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - Ports push, din, pop, dout, empty, full, count.
  - Show-ahead, sync reset, simultaneous push/pop when full allowed.
- Top-level contents: decode, RAM array, counter, LED register and read mux.

Test Plan:
- RAM wrap: store 0xDEADBEEF to 0x00000004, then load 0x00000004 and alias 0x00000104 (RAM_WORDS=64) → both return 0xDEADBEEF. Load 0x00000008 → prior contents unaffected.
- Console drain with backpressure:
  - Write 0x41, 0x42, 0x43 to 0x80000000 with tx_ready=0 → tx_valid=1, tx_data=0x41 held, status=0x0000_0300.
  - Raise tx_ready → 0x41, 0x42, 0x43 appear on consecutive cycles, then tx_valid=0 and status=0x1.
- Overflow:
  - Push 9 bytes with tx_ready=0 (DEPTH=8) → status=0x0000_0806, and the 9th byte is never emitted.
  - Write 0x4 to 0x80000004 → overflow clears, status=0x0000_0802.
- Full plus simultaneous push/pop: with the FIFO full and tx_ready=1, push 0x55 → occupancy stays 8, overflow stays 0, and 0x55 is emitted last.
- Cycle counter:
  - Write 0xFFFFFFFE to 0x80000008 → reads 0xFFFFFFFE next cycle, then 0xFFFFFFFF, then 0x00000000.
  - Reset → reads 0.
- LEDs and reset: write 0x1A5 to 0x8000000C → leds=0xA5, readback 0x000000A5. Assert reset with 3 bytes queued → next cycle leds=0, tx_valid=0, status=0x1.
